// File: rtl/sum_engine_if.sv
// rtl/sum_engine_if.sv - stream sample handshake between stimulus source and sum_engine
interface sum_engine_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface

// File: rtl/sum_engine.sv
// rtl/sum_engine.sv - sequential summation engine: stream sum or repeated add with optional saturation
module sum_engine #(
  parameter int DATA_W   = 8,
  parameter int N_W      = 8,
  parameter int SUM_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [N_W-1:0]   n_i,
  sum_engine_if.slave      s,
  output logic             busy_o,
  output logic             done_o,
  output logic [SUM_W-1:0] sum_o,
  output logic [N_W-1:0]   n_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic MODE_REPEAT = 1'b1;

  state_t            state_q, state_d;
  logic              start_q;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [N_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ovf_q, ovf_d;

  logic              start_rise;
  logic              step;
  logic [DATA_W-1:0] addend;
  logic [SUM_W:0]    add_full;

  // start_q resets high so a switch already on at reset release is not taken as an edge
  assign start_rise = start_i & ~start_q;

  // REPEAT adds the operand latched at start; STREAM adds the live sample
  assign addend   = (mode_q == MODE_REPEAT) ? op_q : s.data_i;
  assign add_full = {1'b0, sum_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, addend};

  // state and datapath registers, cleared to IDLE with all outputs low on reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      mode_q  <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      mode_q  <= mode_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // next-state and datapath update; everything holds unless a start or an add happens
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    step    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          mode_d  = mode_i;
          op_d    = s.data_i;
          cnt_d   = n_i;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = (n_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = (mode_q == MODE_REPEAT) | s.valid_i;
        if (step) begin
          ovf_d = ovf_q | add_full[SUM_W];
          if (SATURATE && add_full[SUM_W]) begin
            sum_d = '1;
          end else begin
            sum_d = add_full[SUM_W-1:0];
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == N_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign s.ready_o = (state_q == RUN) && (mode_q != MODE_REPEAT);
  assign sum_o     = sum_q;
  assign n_o       = cnt_q;
  assign ovf_o     = ovf_q;

endmodule
